// File: rtl/retire_trace_buf.sv
// Retirement-trace capture: classifies each retire event, stamps it with an
// instruction number and queues it for a valid/ready consumer.
// Optional per-record cycle stamp when TRACE_CYCLE_EN is defined.
module retire_trace_buf #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ret_valid,
    input  logic [DATA_W-1:0] ret_pc,
    input  logic              ret_regwrite,
    input  logic [REG_W-1:0]  ret_wreg,
    input  logic [DATA_W-1:0] ret_wdata,
    input  logic              ret_memread,
    input  logic              ret_memwrite,
    input  logic [DATA_W-1:0] ret_addr,
    input  logic [DATA_W-1:0] ret_mdata,
    input  logic              ret_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_kind,
    output logic [CNT_W-1:0]  out_inum,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_wdata,
    output logic [DATA_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_mdata,
    output logic [REG_W-1:0]  out_wreg,
`ifdef TRACE_CYCLE_EN
    output logic [CNT_W-1:0]  out_cycle,
`endif
    output logic              halted,
    output logic              drained,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] K_PLAIN = 3'd0;
    localparam logic [2:0] K_REG   = 3'd1;
    localparam logic [2:0] K_LD    = 3'd2;
    localparam logic [2:0] K_ST    = 3'd3;
    localparam logic [2:0] K_STU   = 3'd4;
    localparam logic [2:0] K_HALT  = 3'd5;

    typedef enum logic {S_CAPTURE, S_HALTED} state_t;

    typedef struct packed {
        logic [2:0]        kind;
        logic [CNT_W-1:0]  inum;
        logic [DATA_W-1:0] pc;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] mdata;
    } rec_t;

    state_t           state_q, state_d;
    rec_t             mem_q [DEPTH];
    rec_t             new_rec, head_rec;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic [CNT_W-1:0] inum_q, drop_q;
    logic             overflow_q;
    logic             evt, push, pop, drop;

    // Classify the event; fields that mean nothing for the kind stay zero.
    always_comb begin
        new_rec      = '0;
        new_rec.pc   = ret_pc;
        new_rec.inum = inum_q;
        if (ret_halt) begin
            new_rec.kind = K_HALT;
        end else if (ret_regwrite && ret_memwrite) begin
            new_rec.kind  = K_STU;
            new_rec.wreg  = ret_wreg;
            new_rec.wdata = ret_wdata;
            new_rec.addr  = ret_addr;
            new_rec.mdata = ret_mdata;
        end else if (ret_memwrite) begin
            new_rec.kind  = K_ST;
            new_rec.addr  = ret_addr;
            new_rec.mdata = ret_mdata;
        end else if (ret_regwrite && ret_memread) begin
            new_rec.kind  = K_LD;
            new_rec.wreg  = ret_wreg;
            new_rec.wdata = ret_wdata;
            new_rec.addr  = ret_addr;
        end else if (ret_regwrite) begin
            new_rec.kind  = K_REG;
            new_rec.wreg  = ret_wreg;
            new_rec.wdata = ret_wdata;
        end else begin
            new_rec.kind = K_PLAIN;
        end
    end

    assign out_valid = (cnt_q != '0);
    assign evt       = ret_valid && (state_q == S_CAPTURE);
    assign pop       = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = evt && ((cnt_q != FULL_CNT) || pop);
    assign drop      = evt && !push;

    always_comb begin
        state_d = state_q;
        if (evt && ret_halt) state_d = S_HALTED;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_CAPTURE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            inum_q     <= '0;
            drop_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + (PTR_W+1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (PTR_W+1)'(1);
            if (evt) inum_q <= inum_q + CNT_W'(1);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
            end
        end
    end

    // NOTE: storage arrays are deliberately not reset; cnt_q alone decides
    // validity, and unread slots are masked to zero on the outputs.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= new_rec;
    end

    assign head_rec   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_kind   = head_rec.kind;
    assign out_inum   = head_rec.inum;
    assign out_pc     = head_rec.pc;
    assign out_wreg   = head_rec.wreg;
    assign out_wdata  = head_rec.wdata;
    assign out_addr   = head_rec.addr;
    assign out_mdata  = head_rec.mdata;

    assign halted     = (state_q == S_HALTED);
    assign drained    = halted && !out_valid;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

`ifdef TRACE_CYCLE_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] cyc_mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) cycle_q <= '0;
        else      cycle_q <= cycle_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push) cyc_mem_q[wr_ptr_q] <= cycle_q;
    end

    assign out_cycle = out_valid ? cyc_mem_q[rd_ptr_q] : '0;
`endif

endmodule

// File: tb/tb_retire_trace_buf.sv
// Scoreboard bench for retire_trace_buf: directed retire events push expected
// records; a negedge monitor compares every record the DUT hands over.
module tb_retire_trace_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ret_valid = 1'b0, ret_regwrite = 1'b0, ret_memread = 1'b0;
    logic        ret_memwrite = 1'b0, ret_halt = 1'b0, out_ready = 1'b0;
    logic [15:0] ret_pc = '0, ret_wdata = '0, ret_addr = '0, ret_mdata = '0;
    logic [2:0]  ret_wreg = '0;
    logic        out_valid, halted, drained, overflow;
    logic [2:0]  out_kind, out_wreg;
    logic [31:0] out_inum, drop_count;
    logic [15:0] out_pc, out_wdata, out_addr, out_mdata;
`ifdef TRACE_CYCLE_EN
    logic [31:0] out_cycle;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inum;
        logic [15:0] pc, wdata, addr, mdata;
        logic [2:0]  wreg;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];

    retire_trace_buf dut (
        .clk(clk), .rst(rst),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_regwrite(ret_regwrite),
        .ret_wreg(ret_wreg), .ret_wdata(ret_wdata), .ret_memread(ret_memread),
        .ret_memwrite(ret_memwrite), .ret_addr(ret_addr), .ret_mdata(ret_mdata),
        .ret_halt(ret_halt),
        .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
        .out_inum(out_inum), .out_pc(out_pc), .out_wdata(out_wdata),
        .out_addr(out_addr), .out_mdata(out_mdata), .out_wreg(out_wreg),
`ifdef TRACE_CYCLE_EN
        .out_cycle(out_cycle),
`endif
        .halted(halted), .drained(drained), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a handshake seen at negedge completes on the next posedge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rec", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("kind",  64'(out_kind),  64'(e.kind));
                check("inum",  64'(out_inum),  64'(e.inum));
                check("pc",    64'(out_pc),    64'(e.pc));
                check("wreg",  64'(out_wreg),  64'(e.wreg));
                check("wdata", 64'(out_wdata), 64'(e.wdata));
                check("addr",  64'(out_addr),  64'(e.addr));
                check("mdata", 64'(out_mdata), 64'(e.mdata));
`ifdef TRACE_CYCLE_EN
                check("cycle", 64'(out_cycle), 64'(e.cyc));
`endif
            end
        end
    end

    // Drive one retire event for the next edge; expected fields are kept
    // only where the hand-given kind makes them meaningful.
    task automatic issue(input logic [15:0] pc, input logic rw, input logic [2:0] wreg,
                         input logic [15:0] wdata, input logic mr, input logic mw,
                         input logic [15:0] addr, input logic [15:0] mdata, input logic halt,
                         input logic keep, input logic [2:0] k, input int inum, input int cyc);
        exp_t e;
        ret_valid = 1'b1; ret_pc = pc; ret_regwrite = rw; ret_wreg = wreg;
        ret_wdata = wdata; ret_memread = mr; ret_memwrite = mw; ret_addr = addr;
        ret_mdata = mdata; ret_halt = halt;
        if (keep) begin
            e.kind  = k;
            e.inum  = 32'(inum);
            e.pc    = pc;
            e.wreg  = (k == 3'd1 || k == 3'd2 || k == 3'd4) ? wreg : 3'd0;
            e.wdata = (k == 3'd1 || k == 3'd2 || k == 3'd4) ? wdata : 16'd0;
            e.addr  = (k == 3'd2 || k == 3'd3 || k == 3'd4) ? addr : 16'd0;
            e.mdata = (k == 3'd3 || k == 3'd4) ? mdata : 16'd0;
            e.cyc   = 32'(cyc);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic reg_evt(input logic [15:0] pc, input logic [2:0] wreg,
                           input logic [15:0] wdata, input logic keep, input int inum);
        issue(pc, 1'b1, wreg, wdata, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, keep, 3'd1, inum, 0);
    endtask

    task automatic idle(input int n);
        ret_valid = 1'b0; ret_halt = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ret_valid = 1'b0;
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
    endtask

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid",    64'(out_valid),  64'd0);
        check("rst_kind",     64'(out_kind),   64'd0);
        check("rst_inum",     64'(out_inum),   64'd0);
        check("rst_pc",       64'(out_pc),     64'd0);
        check("rst_halted",   64'(halted),     64'd0);
        check("rst_drained",  64'(drained),    64'd0);
        check("rst_overflow", 64'(overflow),   64'd0);
        check("rst_drops",    64'(drop_count), 64'd0);

        // Single REG event, visible the cycle after its edge
        out_ready = 1'b1;
        reg_evt(16'h0002, 3'd3, 16'h1234, 1'b1, 0);
        check("lat_valid", 64'(out_valid), 64'd1);
        idle(1);
        wait_empty("drain_reg");

        // ST, LD, STU, PLAIN back to back; stray fields must be zeroed
        do_reset();
        out_ready = 1'b1;
        issue(16'h0004, 1'b0, 3'd6, 16'h9999, 1'b0, 1'b1, 16'h0040, 16'hBEEF, 1'b0, 1'b1, 3'd3, 0, 0);
        issue(16'h0006, 1'b1, 3'd2, 16'h5555, 1'b1, 1'b0, 16'h0080, 16'h4444, 1'b0, 1'b1, 3'd2, 1, 0);
        issue(16'h0008, 1'b1, 3'd5, 16'h0077, 1'b0, 1'b1, 16'h0090, 16'h1111, 1'b0, 1'b1, 3'd4, 2, 0);
        issue(16'h0020, 1'b0, 3'd7, 16'hFFFF, 1'b1, 1'b0, 16'h00AA, 16'h2222, 1'b0, 1'b1, 3'd0, 3, 0);
        idle(1);
        wait_empty("drain_mix");

        // Overflow: DEPTH+2 events with consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++)
            reg_evt(16'(2 * i), 3'(i), 16'(16'h0100 + i), i < 8, i);
        idle(1);
        check("ovf_drops",    64'(drop_count), 64'd2);
        check("ovf_sticky",   64'(overflow),   64'd1);
        check("ovf_head",     64'(out_inum),   64'd0);
        // Full FIFO with a pop in the same cycle still accepts the push
        out_ready = 1'b1;
        reg_evt(16'h0030, 3'd1, 16'h0ABC, 1'b1, 10);
        idle(0);
        check("full_pushpop_drops", 64'(drop_count), 64'd2);
        wait_empty("drain_ovf");

        // HALT then further retires
        do_reset();
        out_ready = 1'b0;
        reg_evt(16'h000E, 3'd1, 16'h0042, 1'b1, 0);
        check("pre_halt", 64'(halted), 64'd0);
        issue(16'h0010, 1'b1, 3'd4, 16'hAAAA, 1'b0, 1'b1, 16'h0033, 16'h0055, 1'b1, 1'b1, 3'd5, 1, 0);
        check("halt_next",    64'(halted),  64'd1);
        check("halt_ndrain",  64'(drained), 64'd0);
        reg_evt(16'h0012, 3'd2, 16'h0001, 1'b0, 2);
        reg_evt(16'h0014, 3'd3, 16'h0002, 1'b0, 3);
        idle(1);
        check("halt_ign_drops", 64'(drop_count), 64'd0);
        out_ready = 1'b1;
        wait_empty("drain_halt");
        check("halt_drained", 64'(drained),   64'd1);
        check("halt_empty",   64'(out_valid), 64'd0);

        // HALT dropped on a full FIFO still closes capture
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            reg_evt(16'(i), 3'd1, 16'(i), 1'b1, i);
        issue(16'h0050, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 3'd5, 8, 0);
        idle(0);
        check("dhalt_halted", 64'(halted),     64'd1);
        check("dhalt_ndrain", 64'(drained),    64'd0);
        check("dhalt_drops",  64'(drop_count), 64'd1);
        out_ready = 1'b1;
        wait_empty("drain_dhalt");
        check("dhalt_drained", 64'(drained), 64'd1);

        // Reset mid-drain discards records and restarts numbering
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            reg_evt(16'(i), 3'd2, 16'(i), 1'b1, i);
        idle(1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        do_reset();
        check("mid_rst_valid", 64'(out_valid),  64'd0);
        check("mid_rst_drops", 64'(drop_count), 64'd0);
        reg_evt(16'h0060, 3'd6, 16'h0066, 1'b1, 0);
        idle(1);
        wait_empty("drain_after_rst");

`ifdef TRACE_CYCLE_EN
        // Cycle stamps at the 3rd and 7th cycle after reset
        do_reset();
        out_ready = 1'b1;
        idle(3);
        issue(16'h0070, 1'b1, 3'd1, 16'h0001, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 3'd1, 0, 3);
        idle(3);
        issue(16'h0072, 1'b1, 3'd1, 16'h0002, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 3'd1, 1, 7);
        idle(1);
        wait_empty("drain_cycle");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
